// File: rtl/step_pulse_gen_pkg.sv
// Shared types and constants for the step pulse generator and its button debouncer.
package step_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } dbnc_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/step_pulse_gen_if.sv
// Stepping sources in, step enable / debounced level / step count out.
interface step_pulse_gen_if #(
  parameter int STEP_W = 16
);
  logic              slow_clk;
  logic              btn;
  logic              auto_mode;
  logic              step_en;
  logic              btn_level;
  logic [STEP_W-1:0] step_count;

  modport master (
    output slow_clk, btn, auto_mode,
    input  step_en, btn_level, step_count
  );

  modport slave (
    input  slow_clk, btn, auto_mode,
    output step_en, btn_level, step_count
  );
endinterface

// File: rtl/step_pulse_gen_btn_debounce.sv
// Push-button synchronizer and debounce FSM; press_pulse is a one-cycle request
// asserted in the cycle a press qualifies, registered downstream with btn_level.
module btn_debounce
  import step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  output logic btn_level,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   btn_s;
  dbnc_state_t            state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   lvl_nxt;

  assign btn_s = btn_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      btn_sync  <= '0;
      state     <= IDLE;
      cnt       <= '0;
      btn_level <= 1'b0;
    end else begin
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn};
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      btn_level <= lvl_nxt;
    end
  end

  // Any disagreement with the level being qualified drops back, so bounces restart the count.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    lvl_nxt     = btn_level;
    press_pulse = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = PRESSED;
          lvl_nxt     = 1'b1;
          press_pulse = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_nxt = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          lvl_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/step_pulse_gen.sv
// Turns slow_clk rising edges (auto) or debounced button presses (manual) into
// single-cycle CLK-domain step enables; slow_clk is only ever sampled as data.
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int STEP_W          = 16
) (
  input  logic               CLK,
  input  logic               RST,
  step_pulse_gen_if.slave    bus
);

  logic [SYNC_STAGES-1:0] slow_sync;
  logic [SYNC_STAGES-1:0] mode_sync;
  logic                   mode_s, mode_prev;
  logic                   slow_rise;
  logic                   press_pulse;
  logic                   btn_level;
  logic                   step_nxt;

  assign mode_s    = mode_sync[SYNC_STAGES-1];
  assign slow_rise = slow_sync[0] & ~slow_sync[1];

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_dbnc (
    .CLK         (CLK),
    .RST         (RST),
    .btn         (bus.btn),
    .btn_level   (btn_level),
    .press_pulse (press_pulse)
  );

  assign bus.btn_level = btn_level;

  // The unselected source is dropped; a mode flip blanks the cycle it lands on.
  always_comb begin
    step_nxt = mode_s ? slow_rise : press_pulse;
    if (mode_s != mode_prev) step_nxt = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      slow_sync      <= '0;
      mode_sync      <= '0;
      mode_prev      <= 1'b0;
      bus.step_en    <= 1'b0;
      bus.step_count <= '0;
    end else begin
      slow_sync   <= {slow_sync[SYNC_STAGES-2:0], bus.slow_clk};
      mode_sync   <= {mode_sync[SYNC_STAGES-2:0], bus.auto_mode};
      mode_prev   <= mode_s;
      bus.step_en <= step_nxt;
      if (bus.step_en) bus.step_count <= bus.step_count + 1'b1;
    end
  end

endmodule

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
- Converts slow or asynchronous stepping sources into single-cycle clock-enable pulses in the CLK domain.
- Sources: the divided clock from clock_div (auto mode) and a bouncing push-button (manual single-step).
- The processor core runs on CLK and advances one instruction per step_en pulse. No logic is clocked from slow_clk.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, number of CLK cycles btn must be stable before a press or release is accepted (10 ms at 100 MHz); minimum legal value 2.
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
- STEP_W, 16, width of step_count.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RST  input  1  synchronous, active-high reset.
- slow_clk  input  1  divided clock from clock_div, treated as data.
- btn  input  1  raw push-button, asynchronous, may bounce.
- auto_mode  input  1  slide switch, asynchronous; 1 = auto stepping, 0 = manual stepping.
- step_en  output  1  one-CLK-cycle step pulse to the core.
- btn_level  output  1  debounced button level.
- step_count  output  STEP_W  number of step_en pulses issued since reset.

Behaviour:
- Reset (RST sampled high at a CLK edge) clears all of the following:
  - all synchronizer flops;
  - FSM to IDLE, debounce counter to 0;
  - outputs: step_en=0, btn_level=0, step_count=0.
- RST has priority over every other event, including mid-debounce and mid-pulse: an in-flight step_en is not issued.
- Synchronizers:
  - btn and auto_mode each pass through 2 flops, giving btn_s and mode_s.
  - slow_clk passes through 2 flops, giving s1 then s2; slow_rise = s1 & ~s2.
- Auto path:
  - Let edge k be the first edge that samples slow_clk=1.
  - step_en is set at edge k+1 and is high for exactly one cycle.
  - Exactly one pulse per slow_clk rising edge. slow_clk falling edges produce nothing.
- Debounce FSM (states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT):
  - IDLE: if btn_s=1, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT:
    - btn_s=0: go to IDLE.
    - else if cnt==DEBOUNCE_CYCLES-1: go to PRESSED, btn_level<=1, raise the manual pulse request.
    - else cnt++.
  - PRESSED: if btn_s=0, go to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT:
    - btn_s=1: go to PRESSED.
    - else if cnt==DEBOUNCE_CYCLES-1: go to IDLE, btn_level<=0.
    - else cnt++.
  - Any bounce restarts qualification, so one accepted press yields exactly one request; holding the button yields no repeats.
- Manual latency: if btn rises before edge k and stays high, step_en is high for one cycle after edge k+DEBOUNCE_CYCLES+2.
- Output mux:
  - step_en <= mode_s ? slow_rise : manual request.
  - The unselected source is discarded, not queued.
  - The FSM keeps running in auto mode, so btn_level stays valid.
- Mode change: on any edge where mode_s differs from its previous registered value, step_en is forced to 0 for that cycle, even if the selected source fires.
- step_count increments on every cycle with step_en=1 and wraps from 2^STEP_W-1 to 0.

Decomposition:
- Shared package step_pkg holds:
  - enum dbnc_state_t {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT};
  - localparam SYNC_STAGES=2.
- One sub-module, btn_debounce: btn synchronizer, FSM, counter; outputs btn_level and a 1-cycle press_pulse.
- Edge detect, mode synchronizer, mux and step_count stay in the top level.

Test Plan:
- RST high 3 cycles, with slow_clk toggling and btn=1 -> step_en=0, btn_level=0, step_count=0 throughout; FSM in IDLE when RST drops.
- auto_mode=1 steady, slow_clk square wave of period 16 CLK, 4 rising edges -> 4 single-cycle step_en pulses, each at edge k+1; step_count=4.
- DEBOUNCE_CYCLES=4, auto_mode=0, btn clean press held 20 cycles -> one step_en pulse one cycle after edge k+6; btn_level=1 until 4 stable-low cycles after release; step_count=1.
- DEBOUNCE_CYCLES=4, btn bouncing 1,0,1,1,0 at 1-cycle spacing then stable high -> exactly one pulse, issued 4 stable cycles after the last bounce; no pulse during the bounce.
- auto_mode toggled in the same cycle a slow_clk edge arrives, then RST asserted while in PRESS_WAIT -> no pulse on the mode-change cycle; RST returns FSM to IDLE, cnt=0, no pulse issued.
- STEP_W=4, 17 auto pulses -> step_count goes 15 -> 0 -> 1.
